pin_filter_bank: RTL and testbench

PIN_FILTER_BANK -- requirements
Module: pin_filter_bank

---
 rtl/pin_filter_bank.sv | 110 +++++++++++
 tb/tb_pin_filter_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pin_filter_bank.sv
// Bank of independent debounce filters for slow board pins, sharing one tick
// prescaler, with per-channel edge pulses and sticky event flags.
module pin_filter_bank #(
   parameter int                 NUM_CH    = 8,
   parameter int                 TICK_MAX  = 33,
   parameter int                 DEB_TICKS = 20,
   parameter logic [NUM_CH-1:0]  INIT      = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] pins_in,
   input  logic [NUM_CH-1:0] bypass,
   input  logic [NUM_CH-1:0] clr_evt,
   output logic              tick_out,
   output logic [NUM_CH-1:0] stable_out,
   output logic [NUM_CH-1:0] rise_out,
   output logic [NUM_CH-1:0] fall_out,
   output logic [NUM_CH-1:0] evt_sticky,
   output logic              any_evt
);

   localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int DW = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic              tick_q, tick_d;
   logic [NUM_CH-1:0] sync1_q, sync2_q;
   logic [NUM_CH-1:0] stable_q, stable_d;
   logic [NUM_CH-1:0] stable_dly_q;
   logic [NUM_CH-1:0] evt_q, evt_d;
   logic [DW-1:0]     deb_q [NUM_CH];
   logic [DW-1:0]     deb_d [NUM_CH];

   // Tick prescaler; tick_q is registered from the next count so it is high
   // exactly while the count sits at its last value.
   always_comb begin
      tcnt_d = tcnt_q;
      if (tcnt_q == TICK_LAST) begin
         tcnt_d = '0;
      end else begin
         tcnt_d = tcnt_q + TW'(1);
      end
      tick_d = (tcnt_d == TICK_LAST);
   end

   // Per-channel debounce: any cycle at the stable level restarts the count.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_CH; i++) begin
         deb_d[i] = deb_q[i];
         if (bypass[i]) begin
            stable_d[i] = sync2_q[i];
            deb_d[i]    = '0;
         end else if (sync2_q[i] == stable_q[i]) begin
            deb_d[i] = '0;
         end else if (tick_q) begin
            if (deb_q[i] == DEB_LAST) begin
               stable_d[i] = sync2_q[i];
               deb_d[i]    = '0;
            end else begin
               deb_d[i] = deb_q[i] + DW'(1);
            end
         end else begin
            deb_d[i] = deb_q[i];
         end
      end
   end

   // Sticky flags: a new edge beats a simultaneous clear.
   always_comb begin
      evt_d = (evt_q & ~clr_evt) | rise_out | fall_out;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q       <= '0;
         tick_q       <= 1'b0;
         sync1_q      <= INIT;
         sync2_q      <= INIT;
         stable_q     <= INIT;
         stable_dly_q <= INIT;
         evt_q        <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            deb_q[i] <= '0;
         end
      end else begin
         tcnt_q       <= tcnt_d;
         tick_q       <= tick_d;
         sync1_q      <= pins_in;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         evt_q        <= evt_d;
         for (int i = 0; i < NUM_CH; i++) begin
            deb_q[i] <= deb_d[i];
         end
      end
   end

   assign tick_out   = tick_q;
   assign stable_out = stable_q;
   assign rise_out   = stable_q & ~stable_dly_q;
   assign fall_out   = ~stable_q & stable_dly_q;
   assign evt_sticky = evt_q;
   assign any_evt    = |evt_q;

endmodule

// File: tb/tb_pin_filter_bank.sv
// Directed bench for pin_filter_bank with NUM_CH=4, TICK_MAX=4, DEB_TICKS=3.
module tb_pin_filter_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pins_in, bypass, clr_evt;
   logic       tick_out, any_evt;
   logic [3:0] stable_out, rise_out, fall_out, evt_sticky;
   logic [17:0] obs;

   int checks = 0;
   int errors = 0;

   pin_filter_bank #(
      .NUM_CH(4), .TICK_MAX(4), .DEB_TICKS(3), .INIT(4'b1111)
   ) dut (
      .clk(clk), .rst(rst), .pins_in(pins_in), .bypass(bypass), .clr_evt(clr_evt),
      .tick_out(tick_out), .stable_out(stable_out), .rise_out(rise_out),
      .fall_out(fall_out), .evt_sticky(evt_sticky), .any_evt(any_evt)
   );

   always #5 clk = ~clk;

   assign obs = {tick_out, any_evt, evt_sticky, fall_out, rise_out, stable_out};

   typedef struct {
      logic [3:0] pins, byp, clr;
      logic [3:0] st, ri, fa, ev;
      logic       an;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic [3:0] pins, byp, clr, st, ri, fa, ev,
                               input logic an);
      vec_t v;
      v.pins = pins; v.byp = byp; v.clr = clr;
      v.st = st; v.ri = ri; v.fa = fa; v.ev = ev; v.an = an;
      return v;
   endfunction

   // Order: {tick, any, evt, fall, rise, stable}
   task automatic chk(input string name, input int idx, input logic [17:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got tick=%b any=%b evt=%b fall=%b rise=%b stable=%b, expected tick=%b any=%b evt=%b fall=%b rise=%b stable=%b",
                  name, idx, obs[17], obs[16], obs[15:12], obs[11:8], obs[7:4], obs[3:0],
                  exp[17], exp[16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] byp);
      rst = 1'b1; pins_in = 4'b1111; bypass = byp; clr_evt = 4'b0000;
      step();
      chk("reset", 0, {1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] st, fa, ev;
      logic       tk;

      tbl[0]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[1]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[2]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[3]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 1'b0);
      tbl[4]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 1'b1);
      tbl[5]  = mk(4'b1111, 4'b1111, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[6]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[7]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      tbl[8]  = mk(4'b1111, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1);
      tbl[9]  = mk(4'b1111, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[10] = mk(4'b0101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[11] = mk(4'b0101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tbl[12] = mk(4'b0101, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b1010, 4'b0000, 1'b0);
      tbl[13] = mk(4'b0101, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1010, 1'b1);
      tbl[14] = mk(4'b0101, 4'b1111, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 4'b1000, 1'b1);
      tbl[15] = mk(4'b0101, 4'b1111, 4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Debounce on ch0 (held low), ch1 glitch of two ticks then a real fall.
      do_reset(4'b0000);
      for (int n = 1; n <= 25; n++) begin
         pins_in = 4'b1111;
         pins_in[0] = 1'b0;
         pins_in[1] = (n >= 9 && n <= 12);
         step();
         tk = (n % 4 == 3);
         st = 4'b1111; fa = 4'b0000; ev = 4'b0000;
         st[0] = (n < 12);  fa[0] = (n == 12); ev[0] = (n >= 13);
         st[1] = (n < 24);  fa[1] = (n == 24); ev[1] = (n >= 25);
         chk("debounce", n, {tk, |ev, ev, fa, 4'b0000, st});
      end

      // Bypass table: tick-independent, 3-edge latency, sticky set/clear.
      do_reset(4'b1111);
      for (int i = 0; i < 16; i++) begin
         pins_in = tbl[i].pins; bypass = tbl[i].byp; clr_evt = tbl[i].clr;
         step();
         tk = ((i + 1) % 4 == 3);
         chk("bypass_tbl", i, {tk, tbl[i].an, tbl[i].ev, tbl[i].fa, tbl[i].ri, tbl[i].st});
      end
      clr_evt = 4'b0000;

      // Reset mid-count on ch3 must discard the partial count.
      do_reset(4'b0000);
      for (int n = 1; n <= 9; n++) begin
         pins_in = 4'b0111;
         step();
         tk = (n % 4 == 3);
         chk("pre_rst", n, {tk, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
      end
      rst = 1'b1;
      #1;
      chk("mid_rst", 0, {1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111});
      @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         pins_in = 4'b0111;
         step();
         tk = (n % 4 == 3);
         st = 4'b1111; fa = 4'b0000; ev = 4'b0000;
         st[3] = (n < 12); fa[3] = (n == 12); ev[3] = (n >= 13);
         chk("post_rst", n, {tk, |ev, ev, fa, 4'b0000, st});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
